// File: rtl/serial_cmd_master_if.sv
// rtl/serial_cmd_master_if.sv - command, UART byte link and response buffer bundle for serial_cmd_master
//
// Signals:
//   cmd_*            command request: opcode, argument bytes, expected response count
//   txBusy/txStart/txData   byte launch towards a UART transmitter
//   rxReady/rxData   received byte strobe from a UART receiver
//   resp_addr/resp_data/resp_count   response buffer read port and fill level
//   busy/done/timeout   status and completion pulses
// modport master: the command engine; modport slave: the surrounding system.

interface serial_cmd_master_if;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [7:0]   cmd_opcode;
  logic [5:0]   cmd_nargs;
  logic [255:0] cmd_args;
  logic [6:0]   cmd_nresp;

  logic         txBusy;
  logic         txStart;
  logic [7:0]   txData;

  logic         rxReady;
  logic [7:0]   rxData;

  logic [5:0]   resp_addr;
  logic [7:0]   resp_data;
  logic [6:0]   resp_count;

  logic         busy;
  logic         done;
  logic         timeout;

  modport master (
    input  cmd_valid, cmd_opcode, cmd_nargs, cmd_args, cmd_nresp,
    input  txBusy, rxReady, rxData, resp_addr,
    output cmd_ready, txStart, txData, resp_data, resp_count,
    output busy, done, timeout
  );

  modport slave (
    output cmd_valid, cmd_opcode, cmd_nargs, cmd_args, cmd_nresp,
    output txBusy, rxReady, rxData, resp_addr,
    input  cmd_ready, txStart, txData, resp_data, resp_count,
    input  busy, done, timeout
  );
endinterface

// File: rtl/serial_cmd_master.sv
// rtl/serial_cmd_master.sv - serial command master: sends opcode + args over a UART, collects responses
//
// Ports:
//   clk   system clock, rising edge
//   rstn  asynchronous active-low reset
//   bus   serial_cmd_master_if.master (command in, UART tx/rx, response buffer, status)
// Parameter:
//   TIMEOUT  response inactivity limit in clk cycles (2 .. 2^24-1)

module serial_cmd_master #(
  parameter int TIMEOUT = 5000000
) (
  input  logic                       clk,
  input  logic                       rstn,
  serial_cmd_master_if.master        bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SEND  = 3'd1,
    GAP   = 3'd2,
    DRAIN = 3'd3,
    RECV  = 3'd4
  } state_t;

  // The timeout pulse is registered, so it is raised on the edge where the
  // counter steps from TIMEOUT-2 to TIMEOUT-1; that puts the pulse in the
  // same cycle the counter reaches its limit.
  localparam logic [23:0] TMO_LAST = 24'(TIMEOUT - 2);

  state_t       state;
  logic [7:0]   opcode_q;
  logic [255:0] args_q;     // shifted right one byte per argument sent
  logic [6:0]   nresp_q;
  logic [5:0]   tx_total;   // 1 + clamped nargs
  logic [5:0]   tx_idx;     // bytes launched so far
  logic         gap_cnt;
  logic [23:0]  tmo_cnt;

  logic [7:0]   resp_mem [0:63];

  logic [5:0]   nargs_c;
  logic [6:0]   nresp_c;
  logic         capture;

  assign nargs_c = (bus.cmd_nargs > 6'd32) ? 6'd32 : bus.cmd_nargs;
  assign nresp_c = (bus.cmd_nresp > 7'd64) ? 7'd64 : bus.cmd_nresp;

  // Completion has priority over a late byte, so the buffer index never
  // exceeds nresp_q-1 (at most 63).
  assign capture = (state == RECV) && (bus.resp_count != nresp_q) && bus.rxReady;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= IDLE;
      bus.cmd_ready  <= 1'b1;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.timeout    <= 1'b0;
      bus.txStart    <= 1'b0;
      bus.txData     <= 8'h00;
      bus.resp_count <= 7'd0;
      opcode_q       <= 8'h00;
      args_q         <= '0;
      nresp_q        <= 7'd0;
      tx_total       <= 6'd0;
      tx_idx         <= 6'd0;
      gap_cnt        <= 1'b0;
      tmo_cnt        <= 24'd0;
    end else begin
      bus.txStart <= 1'b0;
      bus.done    <= 1'b0;
      bus.timeout <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.cmd_valid && bus.cmd_ready) begin
            opcode_q       <= bus.cmd_opcode;
            args_q         <= bus.cmd_args;
            nresp_q        <= nresp_c;
            tx_total       <= nargs_c + 6'd1;
            tx_idx         <= 6'd0;
            bus.resp_count <= 7'd0;
            bus.busy       <= 1'b1;
            bus.cmd_ready  <= 1'b0;
            state          <= SEND;
          end
        end

        SEND: begin
          if (!bus.txBusy) begin
            bus.txStart <= 1'b1;
            if (tx_idx == 6'd0) begin
              bus.txData <= opcode_q;
            end else begin
              bus.txData <= args_q[7:0];
              args_q     <= {8'h00, args_q[255:8]};
            end
            tx_idx  <= tx_idx + 6'd1;
            gap_cnt <= 1'b0;
            state   <= GAP;
          end
        end

        GAP: begin
          if (!gap_cnt) begin
            gap_cnt <= 1'b1;
          end else if (tx_idx != tx_total) begin
            state <= SEND;
          end else if (nresp_q == 7'd0) begin
            state <= DRAIN;
          end else begin
            tmo_cnt <= 24'd0;
            state   <= RECV;
          end
        end

        DRAIN: begin
          if (!bus.txBusy) begin
            bus.done      <= 1'b1;
            bus.busy      <= 1'b0;
            bus.cmd_ready <= 1'b1;
            state         <= IDLE;
          end
        end

        RECV: begin
          if (bus.resp_count == nresp_q) begin
            bus.done      <= 1'b1;
            bus.busy      <= 1'b0;
            bus.cmd_ready <= 1'b1;
            state         <= IDLE;
          end else if (bus.rxReady) begin
            // A byte arriving on the expiry edge wins over the timeout.
            bus.resp_count <= bus.resp_count + 7'd1;
            tmo_cnt        <= 24'd0;
          end else if (tmo_cnt == TMO_LAST) begin
            bus.timeout   <= 1'b1;
            bus.busy      <= 1'b0;
            bus.cmd_ready <= 1'b1;
            tmo_cnt       <= 24'd0;
            state         <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 24'd1;
          end
        end

        default: begin
          state         <= IDLE;
          bus.busy      <= 1'b0;
          bus.cmd_ready <= 1'b1;
        end
      endcase
    end
  end

  // Response buffer keeps its contents through reset; the read port is
  // always live so the last command's bytes can be fetched at any time.
  always_ff @(posedge clk) begin
    if (capture) begin
      resp_mem[bus.resp_count[5:0]] <= bus.rxData;
    end
    bus.resp_data <= resp_mem[bus.resp_addr];
  end

endmodule

// File: tb/tb_serial_cmd_master.sv
// tb/tb_serial_cmd_master.sv - directed self-checking bench for serial_cmd_master

module tb_serial_cmd_master;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  serial_cmd_master_if bus ();

  serial_cmd_master #(.TIMEOUT(100)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int checks = 0;
  int failures = 0;

  // UART transmitter model: busy for 4 cycles after each txStart.
  logic       tx_busy_m = 1'b0;
  int         uart_cnt = 0;
  logic [7:0] tx_q [$];
  int         cyc = 0;

  assign bus.txBusy = tx_busy_m;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.txStart === 1'b1) begin
      tx_q.push_back(bus.txData);
      tx_busy_m <= 1'b1;
      uart_cnt  <= 4;
    end else if (uart_cnt > 1) begin
      uart_cnt <= uart_cnt - 1;
    end else begin
      uart_cnt  <= 0;
      tx_busy_m <= 1'b0;
    end
  end

  // Mid-cycle monitor: pulse counters, event timestamps, protocol rules.
  int   done_n = 0, tmo_n = 0, proto_err = 0;
  int   rx_cyc = 0, tmo_cyc = 0, done_cyc = 0;
  logic done_txbusy = 1'b0;
  logic prev_start = 1'b0, prev_pulse = 1'b0;

  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      done_n++;
      done_cyc = cyc;
      done_txbusy = bus.txBusy;
    end
    if (bus.timeout === 1'b1) begin
      tmo_n++;
      tmo_cyc = cyc;
    end
    if (bus.rxReady === 1'b1) rx_cyc = cyc;
    if (bus.txStart === 1'b1 && (bus.txBusy === 1'b1 || prev_start)) proto_err++;
    if (bus.done === 1'b1 && bus.timeout === 1'b1) proto_err++;
    if (prev_pulse && bus.busy === 1'b1) proto_err++;
    prev_start = (bus.txStart === 1'b1);
    prev_pulse = (bus.done === 1'b1) || (bus.timeout === 1'b1);
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=no_finish expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [7:0] op, input logic [5:0] na,
                       input logic [255:0] args, input logic [6:0] nr);
    bus.cmd_opcode = op;
    bus.cmd_nargs  = na;
    bus.cmd_args   = args;
    bus.cmd_nresp  = nr;
    bus.cmd_valid  = 1'b1;
    step(1);
    bus.cmd_valid  = 1'b0;
  endtask

  task automatic rx_byte(input logic [7:0] b);
    bus.rxData  = b;
    bus.rxReady = 1'b1;
    step(1);
    bus.rxReady = 1'b0;
    step(1);
  endtask

  task automatic wait_tx(input int n, input string tag);
    int k = 0;
    while (tx_q.size() < n && k < 400) begin
      step(1);
      k++;
    end
    chk(tag, tx_q.size(), n);
  endtask

  task automatic wait_end(input int d0, input int t0, input string tag);
    int k = 0;
    while (done_n == d0 && tmo_n == t0 && k < 2000) begin
      step(1);
      k++;
    end
    chk(tag, (k < 2000) ? 1 : 0, 1);
    step(1);
  endtask

  task automatic read_resp(input logic [5:0] a, output logic [7:0] d);
    bus.resp_addr = a;
    step(1);
    d = bus.resp_data;
  endtask

  logic [7:0]   exp2 [0:8];
  logic [7:0]   rd;
  logic [255:0] args6;
  int           d0, t0;

  initial begin
    exp2 = '{8'h0E, 8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
    bus.cmd_valid  = 1'b0;
    bus.cmd_opcode = 8'h00;
    bus.cmd_nargs  = 6'd0;
    bus.cmd_args   = '0;
    bus.cmd_nresp  = 7'd0;
    bus.rxReady    = 1'b0;
    bus.rxData     = 8'h00;
    bus.resp_addr  = 6'd0;
    step(3);

    // Reset state
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_txStart", bus.txStart, 0);
    chk("rst_txData", bus.txData, 0);
    chk("rst_resp_count", bus.resp_count, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_timeout", bus.timeout, 0);
    rstn = 1'b1;
    step(1);

    // Opcode only, one response byte
    tx_q.delete(); d0 = done_n; t0 = tmo_n;
    issue(8'h00, 6'd0, '0, 7'd1);
    wait_tx(1, "t1_txcount");
    chk("t1_txbyte", tx_q[0], 8'h00);
    step(10);
    rx_byte(8'h09);
    wait_end(d0, t0, "t1_end");
    chk("t1_done", done_n - d0, 1);
    chk("t1_no_timeout", tmo_n - t0, 0);
    chk("t1_done_latency", done_cyc - rx_cyc, 2);
    chk("t1_resp_count", bus.resp_count, 1);
    chk("t1_busy_after", bus.busy, 0);
    read_resp(6'd0, rd);
    chk("t1_resp_data0", rd, 8'h09);

    // Eight args, no response: byte order and drain
    tx_q.delete(); d0 = done_n; t0 = tmo_n;
    issue(8'h0E, 6'd8, 256'h0123456789ABCDEF, 7'd0);
    wait_end(d0, t0, "t2_end");
    chk("t2_txcount", tx_q.size(), 9);
    for (int i = 0; i < 9; i++) chk($sformatf("t2_txbyte%0d", i), tx_q[i], exp2[i]);
    chk("t2_done", done_n - d0, 1);
    chk("t2_no_timeout", tmo_n - t0, 0);
    chk("t2_done_txbusy_low", done_txbusy, 0);
    chk("t2_resp_count", bus.resp_count, 0);

    // Timeout after 10 of 64 bytes
    tx_q.delete(); d0 = done_n; t0 = tmo_n;
    issue(8'h10, 6'd0, '0, 7'd64);
    wait_tx(1, "t3_txcount");
    step(10);
    for (int i = 0; i < 10; i++) rx_byte(8'hA0 + 8'(i));
    wait_end(d0, t0, "t3_end");
    chk("t3_timeout", tmo_n - t0, 1);
    chk("t3_no_done", done_n - d0, 0);
    chk("t3_timeout_latency", tmo_cyc - rx_cyc, 100);
    chk("t3_resp_count", bus.resp_count, 10);
    chk("t3_busy_after", bus.busy, 0);
    read_resp(6'd9, rd);
    chk("t3_resp_data9", rd, 8'hA9);
    read_resp(6'd0, rd);
    chk("t3_resp_data0", rd, 8'hA0);

    // rxReady during SEND and a second command while busy
    tx_q.delete(); d0 = done_n; t0 = tmo_n;
    issue(8'h21, 6'd2, 256'hBEEF, 7'd1);
    bus.rxData     = 8'h55;
    bus.rxReady    = 1'b1;
    bus.cmd_opcode = 8'h77;
    bus.cmd_nargs  = 6'd0;
    bus.cmd_nresp  = 7'd0;
    bus.cmd_valid  = 1'b1;
    step(1);
    bus.rxReady   = 1'b0;
    bus.cmd_valid = 1'b0;
    wait_tx(3, "t4_txcount");
    step(10);
    rx_byte(8'h66);
    wait_end(d0, t0, "t4_end");
    step(20);
    chk("t4_no_second_cmd", tx_q.size(), 3);
    chk("t4_txbyte0", tx_q[0], 8'h21);
    chk("t4_txbyte1", tx_q[1], 8'hEF);
    chk("t4_txbyte2", tx_q[2], 8'hBE);
    chk("t4_resp_count", bus.resp_count, 1);
    chk("t4_done", done_n - d0, 1);
    read_resp(6'd0, rd);
    chk("t4_resp_data0", rd, 8'h66);

    // Reset in RECV after 5 bytes, then a command on the first edge
    tx_q.delete();
    issue(8'h30, 6'd0, '0, 7'd8);
    wait_tx(1, "t5_txcount");
    step(10);
    for (int i = 0; i < 5; i++) rx_byte(8'hC0 + 8'(i));
    chk("t5_count_before_rst", bus.resp_count, 5);
    rstn = 1'b0;
    #1;
    chk("t5_rst_txStart", bus.txStart, 0);
    chk("t5_rst_busy", bus.busy, 0);
    chk("t5_rst_resp_count", bus.resp_count, 0);
    chk("t5_rst_cmd_ready", bus.cmd_ready, 1);
    step(2);
    tx_q.delete(); d0 = done_n; t0 = tmo_n;
    bus.cmd_opcode = 8'h08;
    bus.cmd_nargs  = 6'd0;
    bus.cmd_nresp  = 7'd1;
    bus.cmd_valid  = 1'b1;
    rstn = 1'b1;
    step(1);
    bus.cmd_valid = 1'b0;
    chk("t5_accept_first_edge", bus.busy, 1);
    wait_tx(1, "t5_txcount2");
    chk("t5_txbyte", tx_q[0], 8'h08);
    step(10);
    rx_byte(8'h5A);
    wait_end(d0, t0, "t5_end");
    chk("t5_done", done_n - d0, 1);
    chk("t5_no_timeout", tmo_n - t0, 0);
    chk("t5_resp_count", bus.resp_count, 1);
    read_resp(6'd0, rd);
    chk("t5_resp_data0", rd, 8'h5A);

    // Clamping: nargs 40 -> 32, nresp 100 -> 64
    args6 = '0;
    for (int k = 0; k < 32; k++) args6[8*k +: 8] = 8'(k + 1);
    tx_q.delete(); d0 = done_n; t0 = tmo_n;
    issue(8'h40, 6'd40, args6, 7'd100);
    wait_tx(33, "t6_txcount");
    step(10);
    chk("t6_txcount_final", tx_q.size(), 33);
    chk("t6_txbyte1", tx_q[1], 8'h01);
    chk("t6_txbyte32", tx_q[32], 8'h20);
    for (int k = 0; k < 64; k++) rx_byte(8'(k) ^ 8'h3C);
    wait_end(d0, t0, "t6_end");
    chk("t6_resp_count", bus.resp_count, 64);
    chk("t6_done", done_n - d0, 1);
    chk("t6_no_timeout", tmo_n - t0, 0);
    read_resp(6'd63, rd);
    chk("t6_resp_data63", rd, 8'h03);
    read_resp(6'd0, rd);
    chk("t6_resp_data0", rd, 8'h3C);

    chk("protocol_monitor", proto_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_cmd_master.md
SERIAL_CMD_MASTER -- requirements
Module: serial_cmd_master

Interface
REQ-001 Parameter: TIMEOUT, default 5000000, response inactivity timeout in clk cycles (legal range 2 to 2^24-1).
REQ-002 clk  in  1  system clock; all logic on rising edge.
REQ-003 rstn  in  1  asynchronous, active-low reset.
REQ-004 cmd_valid  in  1  command request; accepted when cmd_valid and cmd_ready are both high.
REQ-005 cmd_ready  out  1  high only in IDLE.
REQ-006 cmd_opcode  in  8  command byte, sent first.
REQ-007 cmd_nargs  in  6  argument byte count, 0-32.
REQ-008 cmd_args  in  256  argument byte k at [8k+7:8k]; k=0 sent first.
REQ-009 cmd_nresp  in  7  expected response byte count, 0-64.
REQ-010 txBusy  in  1  UART transmitter busy.
REQ-011 txStart  out  1  one-cycle pulse that launches txData.
REQ-012 txData  out  8  byte to transmit.
REQ-013 rxReady  in  1  one-cycle strobe marking rxData valid.
REQ-014 rxData  in  8  received byte.
REQ-015 resp_addr  in  6  response buffer read address.
REQ-016 resp_data  out  8  buffer[resp_addr], registered, 1-cycle read latency.
REQ-017 resp_count  out  7  response bytes captured for the last command.
REQ-018 busy  out  1  high in every state except IDLE.
REQ-019 done  out  1  one-cycle pulse on successful completion.
REQ-020 timeout  out  1  one-cycle pulse on response timeout.

Function
REQ-021 States: IDLE, SEND, GAP, DRAIN, RECV. No other states are reachable.
REQ-022 On acceptance: latch opcode, args and counts.
- nargs>32 is clamped to 32.
- nresp>64 is clamped to 64.
- Clear resp_count.
- Go to SEND with total tx bytes = 1+nargs.
REQ-023 SEND, when txBusy is low:
- Drive txData with the next byte (opcode, then args in ascending k).
- Pulse txStart for exactly one cycle.
- Go to GAP.
REQ-024 GAP lasts exactly 2 cycles with txStart low.
- Then go to SEND if bytes remain.
- Otherwise go to DRAIN if nresp=0, else RECV.
REQ-025 DRAIN waits for txBusy low, pulses done, then returns to IDLE.
REQ-026 RECV, on each rxReady:
- Write rxData to buffer[resp_count].
- Increment resp_count.
- Clear the timeout counter.
REQ-027 RECV completion: when resp_count reaches nresp, pulse done in the following cycle and return to IDLE.
REQ-028 RECV timeout:
- The timeout counter starts at 0 on entry to RECV and increments each cycle without rxReady.
- On reaching TIMEOUT-1, pulse timeout, hold resp_count, and return to IDLE.
REQ-029 If rxReady coincides with timeout expiry, the byte is captured, the counter clears, and no timeout pulse is issued.
REQ-030 rxReady in IDLE, SEND, GAP or DRAIN is discarded; the buffer and resp_count are unchanged.
REQ-031 cmd_valid while busy is ignored; it is not queued.
REQ-032 The buffer and resp_count hold their values until the next accepted command; resp_addr is readable at any time.
REQ-033 done and timeout are never high in the same cycle; busy is low in the cycle after either pulse.
REQ-034 txStart is never asserted while txBusy is high, nor in 2 consecutive cycles.

Reset
REQ-035 rstn low forces, asynchronously:
- state to IDLE;
- txStart, txData, busy, done, timeout, resp_count and all counters to 0;
- cmd_ready to 1.
Buffer contents are not reset.
REQ-036 Reset mid-operation abandons the command; no done or timeout pulse follows release.
REQ-037 After rstn deasserts, the block accepts a command from the first rising clk edge.

Verification
REQ-038 opcode 0x00, nargs 0, nresp 1, responder returns 0x09 -> one txStart with txData=0x00; done; resp_count=1; resp_data(addr 0)=0x09.
REQ-039 opcode 0x0E, nargs 8, args=0x0123456789ABCDEF, nresp 0 -> tx bytes 0E EF CD AB 89 67 45 23 01 in order; done after final txBusy fall; no timeout.
REQ-040 opcode 0x10, nresp 64, TIMEOUT=100, only 10 bytes returned -> timeout pulse 100 cycles after the 10th rxReady; resp_count=10; no done.
REQ-041 rxReady during SEND, plus a second cmd_valid while busy -> byte not stored; second command ignored; first completes normally.
REQ-042 rstn low during RECV after 5 bytes -> txStart, busy and resp_count go to 0 immediately; after release, opcode 0x08/nresp 1 completes with done.
REQ-043 nargs=40, nresp=100 -> exactly 33 tx bytes sent; completion at 64 response bytes.
